// File: rtl/mux_pkg.sv
// Shared types and constants for the mux select sequencer.
package mux_pkg;

   localparam int unsigned SEL_W  = 3;
   localparam int unsigned DATA_W = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_e;

   // First select position of a word for the given bit order.
   function automatic logic [SEL_W-1:0] sel_first(input logic msb_first);
      return msb_first ? 3'd7 : 3'd0;
   endfunction

   // Final select position of a word for the given bit order.
   function automatic logic [SEL_W-1:0] sel_last(input logic msb_first);
      return msb_first ? 3'd0 : 3'd7;
   endfunction

endpackage

// File: rtl/mux_sel_sequencer_bit_timer.sv
// Loadable down-counter timing how long each select value is held.
module bit_timer #(
   parameter int unsigned            CNT_W  = 8,
   parameter logic [CNT_W-1:0]       RELOAD = '0
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic clr,
   output logic tc
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next count: clear wins over reload; otherwise count down and rest at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = RELOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Parallel-to-serial driver for an 8:1 bit-select mux: holds a word on I
// and walks S through all positions, BIT_CYCLES clocks per position.
module mux_sel_sequencer
   import mux_pkg::*;
#(
   parameter int unsigned BIT_CYCLES = 4,
   parameter int unsigned MSB_FIRST  = 0,
   parameter int unsigned CNT_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic              abort,
   output logic [DATA_W-1:0] I,
   output logic [SEL_W-1:0]  S,
   output logic              bit_valid,
   output logic              last_bit,
   output logic              busy,
   output logic              done
);

   localparam logic [SEL_W-1:0] SEL_FIRST = sel_first(MSB_FIRST != 0);
   localparam logic [SEL_W-1:0] SEL_LAST  = sel_last(MSB_FIRST != 0);
   localparam logic [SEL_W-1:0] SEL_ONE   = SEL_W'(1);
   localparam logic [CNT_W-1:0] RELOAD    = CNT_W'(BIT_CYCLES - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] i_q, i_d;
   logic [SEL_W-1:0]  s_q, s_d, s_step;
   logic              bit_valid_q, bit_valid_d;
   logic              last_bit_q, last_bit_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              timer_load, timer_clr, tc;

   bit_timer #(
      .CNT_W  (CNT_W),
      .RELOAD (RELOAD)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .load (timer_load),
      .clr  (timer_clr),
      .tc   (tc)
   );

   assign load_ready = (state_q == ST_IDLE) & ~rst;

   // Next-state and next-output logic for the IDLE/SHIFT sequencer.
   always_comb begin
      state_d     = state_q;
      i_d         = i_q;
      s_d         = s_q;
      bit_valid_d = bit_valid_q;
      last_bit_d  = last_bit_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      timer_load  = 1'b0;
      timer_clr   = 1'b0;
      s_step      = (MSB_FIRST != 0) ? (s_q - SEL_ONE) : (s_q + SEL_ONE);

      case (state_q)
         ST_IDLE: begin
            // abort is ignored here, so a coincident load is still taken
            if (load_valid && load_ready) begin
               state_d     = ST_SHIFT;
               i_d         = load_data;
               s_d         = SEL_FIRST;
               bit_valid_d = 1'b1;
               last_bit_d  = (SEL_FIRST == SEL_LAST);
               busy_d      = 1'b1;
               timer_load  = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (abort) begin
               state_d     = ST_IDLE;
               s_d         = '0;
               bit_valid_d = 1'b0;
               last_bit_d  = 1'b0;
               busy_d      = 1'b0;
               timer_clr   = 1'b1;
            end else if (tc) begin
               if (s_q == SEL_LAST) begin
                  state_d     = ST_IDLE;
                  s_d         = '0;
                  bit_valid_d = 1'b0;
                  last_bit_d  = 1'b0;
                  busy_d      = 1'b0;
                  done_d      = 1'b1;
                  timer_clr   = 1'b1;
               end else begin
                  s_d        = s_step;
                  last_bit_d = (s_step == SEL_LAST);
                  timer_load = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs, synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         i_q         <= '0;
         s_q         <= '0;
         bit_valid_q <= 1'b0;
         last_bit_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         s_q         <= s_d;
         bit_valid_q <= bit_valid_d;
         last_bit_q  <= last_bit_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign I         = i_q;
   assign S         = s_q;
   assign bit_valid = bit_valid_q;
   assign last_bit  = last_bit_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Parallel-to-serial driver placed directly upstream of the 8:1 bit-select multiplexer.
- Accepts an 8-bit word over a valid/ready handshake and holds it on the mux data bus.
- Steps the 3-bit select through all eight positions, holding each for a programmable number of clocks, so the mux output becomes a serial bitstream.
- Reports per-bit valid, last-bit, busy and a one-cycle completion pulse to the consumer.

Parameters:
- BIT_CYCLES, 4, clocks each select value is held; legal range 1..255.
- MSB_FIRST, 0, 0 = select counts 0→7 (I[0] first); 1 = select counts 7→0 (I[7] first).
- CNT_W, 8, width of the per-bit cycle counter; must satisfy 2^CNT_W > BIT_CYCLES.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- load_data  input  8  word to serialise.
- load_valid  input  1  load_data is valid.
- load_ready  output  1  block can accept a word (high only in IDLE, low while rst is high).
- abort  input  1  terminate the current word.
- I  output  8  held word, wired to the mux data bus.
- S  output  3  select, wired to the mux select.
- bit_valid  output  1  S/I currently present a valid bit.
- last_bit  output  1  the current bit is the 8th of the word.
- busy  output  1  in SHIFT state.
- done  output  1  one-cycle pulse after the 8th bit completes normally.

Behaviour:
- States: IDLE and SHIFT. The state register, I, S, bit counter, cycle counter and done are all registered.
- Reset (rst high at an edge) forces:
  - state = IDLE
  - I = 8'h00, S = 3'b000, cycle counter = 0, bit index = 0
  - bit_valid = 0, last_bit = 0, busy = 0, done = 0
- load_ready:
  - combinational: (state == IDLE) & ~rst.
- Accept:
  - A word is accepted on an edge where load_valid & load_ready.
  - Next cycle: I = load_data; S = 0 (MSB_FIRST = 0) or 7 (MSB_FIRST = 1); bit_valid = 1; busy = 1; state = SHIFT; cycle counter = BIT_CYCLES-1.
- SHIFT stepping:
  - While the cycle counter > 0, decrement it and hold S.
  - When the cycle counter reaches 0 and this is not the last bit: S steps by +1 (or −1 when MSB_FIRST = 1) and the counter reloads to BIT_CYCLES-1.
  - last_bit = 1 while S is the final position (7, or 0 when MSB_FIRST = 1).
- Completion:
  - Trigger: cycle counter = 0 on the last bit.
  - Next cycle: state = IDLE, busy = 0, bit_valid = 0, last_bit = 0, done = 1 for exactly that one cycle.
  - S returns to 0; I holds its last value.
- Timing:
  - Each select value is presented for exactly BIT_CYCLES cycles.
  - SHIFT lasts exactly 8*BIT_CYCLES cycles.
  - The earliest next accept is the cycle in which done is high (load_ready is already 1 then).
  - Minimum word-to-word period is 8*BIT_CYCLES + 1 cycles.
- BIT_CYCLES = 1: S changes every clock; no cycle where S is held twice.
- load_valid during SHIFT is ignored. The word is not captured and must be held by the source until load_ready.
- abort:
  - abort high in SHIFT: next cycle state = IDLE, bit_valid = 0, busy = 0, last_bit = 0, S = 0, done = 0. I holds its value.
  - abort on the same edge as the final step: abort wins and done is not pulsed.
  - abort in IDLE has no effect. A simultaneous load_valid is still accepted.
- rst in mid-word takes effect at the next edge, overrides abort and load, and produces no done pulse.
- The block never outputs X on S. All 8 select codes are reachable.

Decomposition:
- Shared package (mux_pkg):
  - state encoding constants ST_IDLE and ST_SHIFT
  - SEL_W = 3, DATA_W = 8, and the SEL_FIRST/SEL_LAST helper constants derived from MSB_FIRST.
- One natural sub-module, bit_timer: loadable down-counter of width CNT_W with reload value BIT_CYCLES-1, outputting a terminal-count flag.
- The sequencer FSM, select counter and data register stay in mux_sel_sequencer.
- The top-level testbench instantiates mux_sel_sequencer feeding the existing 8:1 mux so the serial output can be checked end to end.

Test Plan:
- Reset, then one word, BIT_CYCLES = 4, MSB_FIRST = 0: load 8'hA5 → I = 8'hA5; S = 0,1,…,7, each for 4 cycles; mux output 1,0,1,0,0,1,0,1; last_bit only during S = 7; done is a single pulse at cycle 33 after accept; busy high for exactly 32 cycles.
- MSB_FIRST = 1, BIT_CYCLES = 1, load 8'h81 → S = 7,6,…,0 on consecutive clocks; mux output 1,0,0,0,0,0,0,1; done on the 9th cycle after accept.
- Back-to-back with load_valid held high carrying 8'h0F then 8'hF0 → the second word is accepted in the done cycle; gap between words is exactly 1 cycle; load_valid during SHIFT never changes I.
- Abort during S = 3 (BIT_CYCLES = 4, word 8'hFF) → next cycle: busy = 0, bit_valid = 0, S = 0, no done pulse; a new load 8'h3C is then serialised correctly from S = 0.
- Abort coincident with the final step → no done pulse; state IDLE next cycle.
- rst asserted mid-word at S = 5 → next cycle: all outputs at reset values (I = 8'h00); load_ready = 0 while rst is high, then 1.
